// File: rtl/bit_scan_sched.sv
// bit_scan_sched: accepts a request vector and emits its set-bit indices
// lowest-first, one per output handshake, then pulses done with the count.
module bit_scan_sched #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] done_cnt
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem;
    logic [IDX_W-1:0] cnt;
    logic             rdy_q;
    logic             in_acc, out_acc;

    // Lowest set bit wins; an empty rem yields index 0.
    always_comb begin
        out_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (rem[i]) out_idx = IDX_W'(i);
    end

    assign out_valid = state == SCAN;
    assign out_last  = out_valid && (rem & (rem - 1'b1)) == '0;
    assign busy      = out_valid;
    assign in_ready  = state == IDLE && rdy_q;
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;

    always_comb begin
        state_nxt = (in_acc && in_data != '0) ? SCAN :
                    (out_acc && out_last)     ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            cnt      <= '0;
            rdy_q    <= 1'b0;
            done     <= 1'b0;
            done_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rdy_q    <= 1'b1;
            done     <= (in_acc && in_data == '0) || (out_acc && out_last);
            done_cnt <= (out_acc && out_last) ? cnt + 1'b1 : '0;
            if (in_acc) begin
                rem <= in_data;
                cnt <= '0;
            end else if (out_acc) begin
                rem <= rem & (rem - 1'b1);
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bit_scan_sched.sv
// tb_bit_scan_sched: directed and random checks of bit_scan_sched against a
// queue-of-indices reference model.
module tb_bit_scan_sched;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [5:0]  done_cnt;

    bit_scan_sched dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .busy(busy), .done(done), .done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int q[$];
    int emitted = 0;
    bit m_done = 0;
    int m_done_cnt = 0;
    bit m_rdy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        int n;
        n = q.size();
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        chk("out_idx", 32'(out_idx), (n > 0) ? q[0] : 0);
        chk("out_last", 32'(out_last), 32'(n == 1));
        chk("busy", 32'(busy), 32'(n > 0));
        chk("in_ready", 32'(in_ready), 32'(m_rdy && n == 0));
        chk("done", 32'(done), 32'(m_done));
        chk("done_cnt", 32'(done_cnt), m_done ? m_done_cnt : 0);
    endtask

    // Drive one cycle of inputs, check the current outputs, then advance the model.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy);
        bit acc, hs;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        check_outs();
        acc = iv && m_rdy && q.size() == 0;
        hs  = q.size() > 0 && ordy;
        @(posedge clk);
        #1;
        m_done = 0;
        if (acc) begin
            emitted = 0;
            for (int i = 0; i < 32; i++)
                if (d[i]) q.push_back(i);
            if (q.size() == 0) begin
                m_done = 1;
                m_done_cnt = 0;
            end
        end else if (hs) begin
            void'(q.pop_front());
            emitted++;
            if (q.size() == 0) begin
                m_done = 1;
                m_done_cnt = emitted;
            end
        end
        m_rdy = 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_done = 0;
        m_rdy = 0;
        check_outs();
        rst = 1'b0;
    endtask

    // toggle=1 alternates out_ready starting low to exercise backpressure.
    task automatic run_vec(input logic [31:0] v, input bit toggle);
        int k;
        cycle(1'b1, v, 1'b1);
        k = 0;
        while (!m_done && k < 200) begin
            cycle(1'b0, '0, toggle ? logic'(k[0]) : 1'b1);
            k++;
        end
        cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        do_reset();
        cycle(1'b0, '0, 1'b1);
        run_vec(32'h0000_0001, 1'b0);
        run_vec(32'h8000_0011, 1'b0);
        run_vec(32'hFFFF_FFFF, 1'b1);
        run_vec(32'h0000_0000, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h0000_0003, 1'b1);
        repeat (3) cycle(1'b1, 32'h0000_0F00, 1'b1);
        repeat (5) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h0000_00FF, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        do_reset();
        cycle(1'b0, '0, 1'b1);
        run_vec(32'h0000_0002, 1'b0);
        repeat (800)
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom),
                  1'($urandom_range(0, 9) < 7));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
